// File: rtl/prbs_checker_pkg.sv
// Shared PRBS definitions: checker FSM states and the Galois LFSR update,
// usable by the generator, the checker and any reference model.
package prbs_checker_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int unsigned MAX_W = 64;
  localparam int unsigned IDX_W = $clog2(MAX_W);

  // Width-generic step: callers zero-extend to MAX_W and pass their live width w.
  function automatic logic [MAX_W-1:0] lfsr_step(input logic [MAX_W-1:0] s,
                                                 input logic [MAX_W-1:0] poly,
                                                 input int unsigned      w);
    logic [MAX_W-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < MAX_W - 1; i++) begin
      if (i + 1 < w) n[i] = s[i+1] ^ (poly[i] & s[0]);
    end
    n[IDX_W'(w - 1)] = s[0];
    return n;
  endfunction

endpackage

// File: rtl/prbs_checker_sat_cnt.sv
// Saturating accumulator with synchronous clear; clear beats a same-cycle add.
module prbs_sat_cnt #(
  parameter int unsigned W  = 16,
  parameter int unsigned IW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [IW-1:0] inc,
  output logic [W-1:0]  cnt
);

  localparam int unsigned SW = ((W > IW) ? W : IW) + 1;
  localparam logic [SW-1:0] MAXV = SW'({W{1'b1}});

  logic [SW-1:0] sum;

  assign sum = SW'(cnt) + SW'(inc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (sum > MAXV) ? {W{1'b1}} : W'(sum);
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// PRBS receive checker: self-seeds from incoming LFSR words, locks after a run
// of matches, then free-runs its reference and counts errored words and bits.
module prbs_checker
  import prbs_checker_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] POLY       = '0,
  parameter int unsigned           LOCK_CNT   = 8,
  parameter int unsigned           UNLOCK_CNT = 4,
  parameter int unsigned           CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  vld_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  input  logic                  clr_i,
  output logic                  lock_o,
  output logic                  err_o,
  output logic [CNT_WIDTH-1:0]  err_cnt_o,
  output logic [CNT_WIDTH-1:0]  err_bits_o
);

  localparam int unsigned MW = $clog2(LOCK_CNT + 1);
  localparam int unsigned UW = $clog2(UNLOCK_CNT + 1);
  localparam int unsigned PW = $clog2(DATA_WIDTH + 1);

  state_t                state, nxt_state;
  logic [DATA_WIDTH-1:0] exp, nxt_exp;
  logic [MW-1:0]         match_cnt, nxt_match;
  logic [UW-1:0]         miss_cnt, nxt_miss;
  logic                  nxt_err;
  logic [DATA_WIDTH-1:0] step_dat, step_exp, diff;
  logic [PW-1:0]         pop;

  assign step_dat = DATA_WIDTH'(lfsr_step(MAX_W'(dat_i), MAX_W'(POLY), DATA_WIDTH));
  assign step_exp = DATA_WIDTH'(lfsr_step(MAX_W'(exp), MAX_W'(POLY), DATA_WIDTH));
  assign diff     = dat_i ^ exp;

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      pop = pop + PW'(diff[i]);
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_exp   = exp;
    nxt_match = match_cnt;
    nxt_miss  = miss_cnt;
    nxt_err   = 1'b0;
    if (vld_i) begin
      case (state)
        SEARCH: begin
          // All-zero is the LFSR fixed point and cannot seed a sequence.
          if (dat_i != '0) begin
            nxt_exp   = step_dat;
            nxt_match = '0;
            nxt_state = VERIFY;
          end
        end
        VERIFY: begin
          if (dat_i == exp) begin
            nxt_exp   = step_dat;
            nxt_match = match_cnt + MW'(1);
            if (match_cnt == MW'(LOCK_CNT - 1)) begin
              nxt_state = LOCKED;
              nxt_miss  = '0;
            end
          end else if (dat_i != '0) begin
            nxt_exp   = step_dat;
            nxt_match = '0;
          end else begin
            nxt_match = '0;
            nxt_state = SEARCH;
          end
        end
        LOCKED: begin
          // Reference free-runs so corrupted words never disturb it.
          nxt_exp = step_exp;
          if (dat_i == exp) begin
            nxt_miss = '0;
          end else begin
            nxt_err  = 1'b1;
            nxt_miss = miss_cnt + UW'(1);
            if (miss_cnt == UW'(UNLOCK_CNT - 1)) begin
              nxt_state = SEARCH;
              nxt_miss  = '0;
              nxt_match = '0;
            end
          end
        end
        default: begin
          nxt_state = SEARCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= SEARCH;
      exp       <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      err_o     <= 1'b0;
      lock_o    <= 1'b0;
    end else begin
      state     <= nxt_state;
      exp       <= nxt_exp;
      match_cnt <= nxt_match;
      miss_cnt  <= nxt_miss;
      err_o     <= nxt_err;
      lock_o    <= (nxt_state == LOCKED);
    end
  end

  prbs_sat_cnt #(.W(CNT_WIDTH), .IW(1)) u_err_cnt (
    .clk (clk_i),
    .rst (rst_i),
    .clr (clr_i),
    .en  (nxt_err),
    .inc (1'b1),
    .cnt (err_cnt_o)
  );

  prbs_sat_cnt #(.W(CNT_WIDTH), .IW(PW)) u_err_bits (
    .clk (clk_i),
    .rst (rst_i),
    .clr (clr_i),
    .en  (nxt_err),
    .inc (pop),
    .cnt (err_bits_o)
  );

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker with a 4-bit LFSR (POLY=1, period 15).
module tb_prbs_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vld = 1'b0;
  logic [3:0] dat = 4'h0;
  logic       clr = 1'b0;
  logic       lock;
  logic       err;
  logic [3:0] err_cnt;
  logic [3:0] err_bits;

  int passed = 0;
  int total  = 0;
  int idx    = 0;

  logic [3:0] seq [15] = '{4'h1, 4'h9, 4'hD, 4'hF, 4'hE, 4'h7, 4'hA, 4'h5,
                          4'hB, 4'hC, 4'h6, 4'h3, 4'h8, 4'h4, 4'h2};

  prbs_checker #(
    .DATA_WIDTH (4),
    .POLY       (4'h1),
    .LOCK_CNT   (3),
    .UNLOCK_CNT (2),
    .CNT_WIDTH  (4)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .vld_i      (vld),
    .dat_i      (dat),
    .clr_i      (clr),
    .lock_o     (lock),
    .err_o      (err),
    .err_cnt_o  (err_cnt),
    .err_bits_o (err_bits)
  );

  always #5 clk = ~clk;

  // Present one valid word, sample the outputs 1 time unit after the edge.
  task automatic beat(input logic [3:0] d, input logic c);
    vld = 1'b1;
    dat = d;
    clr = c;
    @(posedge clk);
    #1;
    vld = 1'b0;
    clr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    idle(3);
    @(negedge clk);
    rst = 1'b0;
    idle(3);
    total++; if (lock !== 1'b0) $display("FAIL reset_lock: got %0b want 0", lock); else passed++;
    total++; if (err !== 1'b0) $display("FAIL reset_err: got %0b want 0", err); else passed++;
    total++; if (err_cnt !== 4'd0) $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); else passed++;
    total++; if (err_bits !== 4'd0) $display("FAIL reset_err_bits: got %0d want 0", err_bits); else passed++;
  endtask

  task automatic test_lock;
    beat(4'h1, 1'b0);
    beat(4'h9, 1'b0);
    idle(2);
    beat(4'hD, 1'b0);
    idle(3);
    total++; if (lock !== 1'b0) $display("FAIL lock_early: got %0b want 0", lock); else passed++;
    beat(4'hF, 1'b0);
    total++; if (lock !== 1'b1) $display("FAIL lock_after_F: got %0b want 1", lock); else passed++;
    total++; if (err_cnt !== 4'd0) $display("FAIL lock_err_cnt: got %0d want 0", err_cnt); else passed++;
    idle(2);
    total++; if (lock !== 1'b1 || err !== 1'b0) $display("FAIL lock_gap: lock=%0b err=%0b want 1,0", lock, err); else passed++;
  endtask

  task automatic test_single_error;
    beat(4'hE, 1'b0);
    beat(4'h7, 1'b0);
    beat(4'h0, 1'b0);
    total++; if (err !== 1'b1) $display("FAIL single_err_pulse: got %0b want 1", err); else passed++;
    total++; if (err_cnt !== 4'd1) $display("FAIL single_err_cnt: got %0d want 1", err_cnt); else passed++;
    total++; if (err_bits !== 4'd2) $display("FAIL single_err_bits: got %0d want 2", err_bits); else passed++;
    total++; if (lock !== 1'b1) $display("FAIL single_lock: got %0b want 1", lock); else passed++;
    beat(4'h5, 1'b0);
    total++; if (err !== 1'b0) $display("FAIL single_err_clears: got %0b want 0", err); else passed++;
    total++; if (err_cnt !== 4'd1) $display("FAIL single_cnt_hold: got %0d want 1", err_cnt); else passed++;
  endtask

  task automatic test_unlock_relock;
    beat(4'h0, 1'b0);
    total++; if (lock !== 1'b1 || err !== 1'b1) $display("FAIL unlock_first: lock=%0b err=%0b want 1,1", lock, err); else passed++;
    total++; if (err_bits !== 4'd5) $display("FAIL unlock_bits1: got %0d want 5", err_bits); else passed++;
    beat(4'h0, 1'b0);
    total++; if (lock !== 1'b0) $display("FAIL unlock_second: got %0b want 0", lock); else passed++;
    total++; if (err_cnt !== 4'd3) $display("FAIL unlock_cnt: got %0d want 3", err_cnt); else passed++;
    total++; if (err_bits !== 4'd7) $display("FAIL unlock_bits2: got %0d want 7", err_bits); else passed++;
    beat(4'h6, 1'b0);
    beat(4'h3, 1'b0);
    beat(4'h8, 1'b0);
    total++; if (lock !== 1'b0) $display("FAIL relock_early: got %0b want 0", lock); else passed++;
    beat(4'h4, 1'b0);
    total++; if (lock !== 1'b1) $display("FAIL relock: got %0b want 1", lock); else passed++;
    total++; if (err_cnt !== 4'd3) $display("FAIL relock_cnt: got %0d want 3", err_cnt); else passed++;
  endtask

  task automatic test_search;
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (lock !== 1'b0 || err_cnt !== 4'd0 || err_bits !== 4'd0)
      $display("FAIL async_reset: lock=%0b cnt=%0d bits=%0d want 0,0,0", lock, err_cnt, err_bits); else passed++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      beat(4'h0, 1'b0);
      total++; if (lock !== 1'b0 || err !== 1'b0) $display("FAIL search_zero: lock=%0b err=%0b want 0,0", lock, err); else passed++;
    end
    beat(4'h7, 1'b0);
    beat(4'h9, 1'b0);
    beat(4'hD, 1'b0);
    beat(4'hF, 1'b0);
    total++; if (lock !== 1'b0) $display("FAIL reseed_no_lock: got %0b want 0", lock); else passed++;
    beat(4'hE, 1'b0);
    total++; if (lock !== 1'b1) $display("FAIL reseed_lock: got %0b want 1", lock); else passed++;
    total++; if (err_cnt !== 4'd0) $display("FAIL reseed_cnt: got %0d want 0", err_cnt); else passed++;
    idx = 5;
  endtask

  task automatic test_clr_sat;
    beat(seq[idx] ^ 4'hF, 1'b1);
    idx = (idx + 1) % 15;
    total++; if (err !== 1'b1) $display("FAIL clr_err_pulse: got %0b want 1", err); else passed++;
    total++; if (err_cnt !== 4'd0 || err_bits !== 4'd0) $display("FAIL clr_wins: cnt=%0d bits=%0d want 0,0", err_cnt, err_bits); else passed++;
    total++; if (lock !== 1'b1) $display("FAIL clr_lock: got %0b want 1", lock); else passed++;
    beat(seq[idx], 1'b0);
    idx = (idx + 1) % 15;
    for (int i = 0; i < 16; i++) begin
      beat(seq[idx] ^ 4'hF, 1'b0);
      idx = (idx + 1) % 15;
      if (i == 0) begin
        total++; if (err_cnt !== 4'd1) $display("FAIL sat_first: got %0d want 1", err_cnt); else passed++;
      end
      if (i == 3) begin
        total++; if (err_bits !== 4'd15) $display("FAIL bits_clamp: got %0d want 15", err_bits); else passed++;
      end
      if (i == 14) begin
        total++; if (err_cnt !== 4'd15) $display("FAIL sat_reach: got %0d want 15", err_cnt); else passed++;
      end
      beat(seq[idx], 1'b0);
      idx = (idx + 1) % 15;
    end
    total++; if (err_cnt !== 4'd15) $display("FAIL sat_hold: got %0d want 15", err_cnt); else passed++;
    total++; if (err_bits !== 4'd15) $display("FAIL bits_hold: got %0d want 15", err_bits); else passed++;
    total++; if (lock !== 1'b1) $display("FAIL sat_lock: got %0b want 1", lock); else passed++;
    beat(seq[idx], 1'b1);
    idx = (idx + 1) % 15;
    total++; if (err_cnt !== 4'd0 || err_bits !== 4'd0 || err !== 1'b0)
      $display("FAIL clr_plain: cnt=%0d bits=%0d err=%0b want 0,0,0", err_cnt, err_bits, err); else passed++;
  endtask

  initial begin
    test_reset;
    test_lock;
    test_single_error;
    test_unlock_relock;
    test_search;
    test_clr_sat;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
